// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate L1 data cache
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   p1_addr_i / p1_data_i    CPU byte address and store data
//   p1_MemRead_i/_MemWrite_i load / store request (both high = store)
//   p1_data_o                load data (combinational, 0 unless read hit)
//   p1_stall_o               pipeline freeze while a miss is serviced
//   mem_*                    256-bit line interface, level request held until mem_ack_i
module dcache_controller #(
    parameter int LINE_BITS = 256,
    parameter int NUM_LINES = 32,
    parameter int TAG_W     = 22
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          p1_addr_i,
    input  logic [31:0]          p1_data_i,
    input  logic                 p1_MemRead_i,
    input  logic                 p1_MemWrite_i,
    output logic [31:0]          p1_data_o,
    output logic                 p1_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);
    localparam int IDX_W = $clog2(NUM_LINES);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MISS       = 3'd1,
        WRITEBACK  = 3'd2,
        READMISS   = 3'd3,
        READMISSOK = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_LINES-1:0]   valid_q, dirty_q;
    logic [TAG_W-1:0]       tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0]   data_q [NUM_LINES];

    logic [TAG_W-1:0]       tag;
    logic [IDX_W-1:0]       idx;
    logic [2:0]             wsel;
    logic [LINE_BITS-1:0]   cur_line;
    logic                   req, hit, wr_hit, refill;
    logic                   unused_addr_lsbs;

    assign tag              = p1_addr_i[31 -: TAG_W];
    assign idx              = p1_addr_i[5 +: IDX_W];
    assign wsel             = p1_addr_i[4:2];
    assign unused_addr_lsbs = ^p1_addr_i[1:0];
    assign cur_line         = data_q[idx];
    assign req              = p1_MemRead_i | p1_MemWrite_i;
    assign hit              = valid_q[idx] && (tag_q[idx] == tag);
    assign wr_hit           = (state_q == IDLE) && p1_MemWrite_i && hit;
    assign refill           = (state_q == READMISS) && mem_ack_i;
    assign p1_stall_o       = (state_q != IDLE) || (req && !hit);
    // Returns the pre-write word when a store hits in the same cycle
    assign p1_data_o        = (p1_MemRead_i && hit) ? cur_line[{wsel, 5'b0} +: 32] : 32'h0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == WRITEBACK && mem_ack_i) dirty_q[idx] <= 1'b0;
            if (refill) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
            if (wr_hit) dirty_q[idx] <= 1'b1;
        end
    end

    // Tags and line data need no reset; valid bits gate their use
    always_ff @(posedge clk_i) begin
        if (refill) begin
            data_q[idx] <= mem_data_i;
            tag_q[idx]  <= tag;
        end else if (wr_hit) begin
            data_q[idx][{wsel, 5'b0} +: 32] <= p1_data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       state_d = (req && !hit) ? MISS : IDLE;
            MISS:       state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : READMISS;
            WRITEBACK:  state_d = mem_ack_i ? READMISS : WRITEBACK;
            READMISS:   state_d = mem_ack_i ? READMISSOK : READMISS;
            READMISSOK: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_enable_o = (state_q == WRITEBACK) || (state_q == READMISS);
        mem_write_o  = (state_q == WRITEBACK);
        mem_addr_o   = (state_q == WRITEBACK) ? {tag_q[idx], idx, 5'b0} :
                       (state_q == READMISS)  ? {tag, idx, 5'b0} : 32'h0;
        mem_data_o   = (state_q == WRITEBACK) ? cur_line : '0;
    end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed checks of the data cache against a line memory model
module tb_dcache_controller;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  p1_addr_i, p1_data_i, p1_data_o, mem_addr_o;
    logic         p1_MemRead_i, p1_MemWrite_i, p1_stall_o;
    logic         mem_enable_o, mem_write_o, mem_ack_i;
    logic [255:0] mem_data_o, mem_data_i;

    logic [255:0] mem [0:127];
    int           lat = 4;
    int           n_chk = 0, n_pass = 0;
    logic         wb_seen, rd_seen, rd_write;
    logic [31:0]  wb_addr, rd_addr;
    logic [255:0] wb_data;

    dcache_controller dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
        .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
        .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Memory: ack pulses on the lat-th cycle that enable is seen high
    initial begin
        int cnt;
        cnt = 0;
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (mem_enable_o) begin
                cnt++;
                if (cnt == lat) begin
                    cnt = 0;
                    mem_ack_i = 1'b1;
                    if (mem_write_o) mem[mem_addr_o[11:5]] = mem_data_o;
                    else mem_data_i = mem[mem_addr_o[11:5]];
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Presents one access, counts stall cycles, records memory traffic,
    // captures the load data of the completing cycle, then retires it on one edge
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output int st, output logic [31:0] q);
        p1_MemRead_i = rd;
        p1_MemWrite_i = wr;
        p1_addr_i = a;
        p1_data_i = d;
        wb_seen = 1'b0;
        rd_seen = 1'b0;
        rd_write = 1'b0;
        wb_addr = '0;
        rd_addr = '0;
        wb_data = '0;
        st = 0;
        #1;
        while (p1_stall_o && st < 100) begin
            @(posedge clk_i);
            #1;
            st++;
            if (mem_enable_o && mem_write_o && !wb_seen) begin
                wb_seen = 1'b1;
                wb_addr = mem_addr_o;
                wb_data = mem_data_o;
            end
            if (mem_enable_o && !mem_write_o && !rd_seen) begin
                rd_seen = 1'b1;
                rd_addr = mem_addr_o;
                rd_write = mem_write_o;
            end
        end
        q = p1_data_o;
        tick();
        p1_MemRead_i = 1'b0;
        p1_MemWrite_i = 1'b0;
    endtask

    initial begin
        int st, k;
        logic [31:0] q;
        logic [255:0] exp_line;
        for (int l = 0; l < 128; l++)
            for (int w = 0; w < 8; w++)
                mem[l][w*32 +: 32] = (l << 16) | w;
        mem[2] = '0;
        mem[2][95:64] = 32'hDEADBEEF;
        rst_i = 1'b1;
        p1_addr_i = '0;
        p1_data_i = '0;
        p1_MemRead_i = 1'b0;
        p1_MemWrite_i = 1'b0;
        #2;
        chk("rst_stall_noreq", {255'b0, p1_stall_o}, 256'd0);
        chk("rst_mem_en", {255'b0, mem_enable_o}, 256'd0);
        chk("rst_mem_addr", {224'b0, mem_addr_o}, 256'd0);
        chk("rst_mem_data", mem_data_o, 256'd0);
        p1_MemRead_i = 1'b1;
        p1_addr_i = 32'h40;
        #1;
        chk("rst_stall_req", {255'b0, p1_stall_o}, 256'd1);
        chk("rst_data", {224'b0, p1_data_o}, 256'd0);
        p1_MemRead_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();

        access(1, 0, 32'h40, 0, st, q);
        chk("cold_stall", st, 7);
        chk("cold_rd_addr", {224'b0, rd_addr}, 256'h40);
        chk("cold_rd_seen", {254'b0, rd_seen, rd_write}, 256'd2);
        chk("cold_no_wb", {255'b0, wb_seen}, 256'd0);
        chk("cold_word0", {224'b0, q}, 256'd0);
        access(1, 0, 32'h48, 0, st, q);
        chk("hit_stall", st, 0);
        chk("hit_word2", {224'b0, q}, 256'hDEADBEEF);

        access(0, 1, 32'h44, 32'h12345678, st, q);
        chk("wrhit_stall", st, 0);
        chk("wrhit_data_o", {224'b0, q}, 256'd0);
        chk("wrhit_dirty", {255'b0, dut.dirty_q[2]}, 256'd1);
        access(1, 0, 32'h44, 0, st, q);
        chk("wrhit_readback", {224'b0, q}, 256'h12345678);

        access(1, 0, 32'h440, 0, st, q);
        exp_line = '0;
        exp_line[95:64] = 32'hDEADBEEF;
        exp_line[63:32] = 32'h12345678;
        chk("evict_stall", st, 11);
        chk("evict_wb_addr", {224'b0, wb_addr}, 256'h40);
        chk("evict_wb_data", wb_data, exp_line);
        chk("evict_rd_addr", {224'b0, rd_addr}, 256'h440);
        chk("evict_mem_line", mem[2], exp_line);
        chk("evict_word0", {224'b0, q}, 256'h00220000);

        access(0, 1, 32'h80, 32'hA5A5A5A5, st, q);
        chk("stmiss_stall", st, 7);
        chk("stmiss_dirty", {255'b0, dut.dirty_q[4]}, 256'd1);
        access(1, 0, 32'h80, 0, st, q);
        chk("stmiss_word0", {224'b0, q}, 256'hA5A5A5A5);
        access(1, 0, 32'h84, 0, st, q);
        chk("stmiss_word1", {224'b0, q}, 256'h00040001);
        access(1, 0, 32'h9C, 0, st, q);
        chk("stmiss_word7", {224'b0, q}, 256'h00040007);

        access(1, 1, 32'h84, 32'hCAFEF00D, st, q);
        chk("rw_stall", st, 0);
        chk("rw_old_word", {224'b0, q}, 256'h00040001);
        access(1, 0, 32'h84, 0, st, q);
        chk("rw_new_word", {224'b0, q}, 256'hCAFEF00D);

        p1_MemRead_i = 1'b1;
        p1_addr_i = 32'hC0;
        k = 0;
        while (!mem_enable_o && k < 20) begin
            tick();
            k++;
        end
        chk("rstmid_reached_readmiss", {255'b0, mem_enable_o}, 256'd1);
        rst_i = 1'b1;
        #1;
        chk("rstmid_en_fall", {255'b0, mem_enable_o}, 256'd0);
        chk("rstmid_state", {253'b0, dut.state_q}, 256'd0);
        chk("rstmid_stall", {255'b0, p1_stall_o}, 256'd1);
        p1_MemRead_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();
        access(1, 0, 32'hC0, 0, st, q);
        chk("rstmid_remiss_stall", st, 7);
        chk("rstmid_remiss_data", {224'b0, q}, 256'h00060000);
        access(1, 0, 32'h48, 0, st, q);
        chk("rstmid_invalidated", st, 7);
        chk("rstmid_reload", {224'b0, q}, 256'hDEADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
